// File: rtl/ifu_fetch.sv
// Instruction fetch stage: issues one AXI-style read per instruction, handles
// misalignment, bus errors, response timeouts and redirects from the PC stage.
module ifu_fetch #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        pc_update
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W:0] WAIT_LIM = 9'(MAX_WAIT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;
  logic [1:0]         inst_err_q, inst_err_d;
  logic               pending_q, pending_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               inst_valid_q, inst_valid_d;

  logic [CNT_W-1:0]   wait_inc;
  logic               wait_expired;

  // Saturating wait count; expiry fires on the cycle the count would reach MAX_WAIT.
  assign wait_inc     = (wait_q == '1) ? wait_q : wait_q + CNT_W'(1);
  assign wait_expired = (({1'b0, wait_q} + 9'd1) >= WAIT_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_err_q   <= ERR_OK;
      pending_q    <= 1'b0;
      kill_q       <= 1'b0;
      wait_q       <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
      pending_q    <= pending_d;
      kill_q       <= kill_d;
      wait_q       <= wait_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    pending_d  = pending_q;
    kill_d     = kill_q;
    wait_d     = wait_q;
    pc_update  = 1'b0;

    // An orphaned response is swallowed by the first rvalid seen while pending.
    if (pending_q && rvalid) begin
      pending_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (fetch_en && !flush && !pending_q) begin
          araddr_d  = pc;
          inst_pc_d = pc;
          if (pc[1:0] == 2'b00) begin
            state_d = S_AR;
          end else begin
            inst_d     = '0;
            inst_err_d = ERR_ALIGN;
            state_d    = S_OUT;
          end
        end
      end
      S_AR: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (arready) begin
          kill_d = 1'b0;
          wait_d = '0;
          if (kill_q || flush) begin
            pending_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_R;
          end
        end
      end
      S_R: begin
        if (rvalid) begin
          // A response arriving with a flush is consumed here, so nothing is left owing.
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            inst_d     = rdata;
            inst_err_d = (rresp != 2'b00) ? ERR_BUS : ERR_OK;
            state_d    = S_OUT;
          end
        end else if (flush) begin
          pending_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_inc;
          if (wait_expired) begin
            inst_d     = '0;
            inst_err_d = ERR_TIMEOUT;
            pending_d  = 1'b1;
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (inst_ready) begin
          pc_update = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    arvalid_d    = (state_d == S_AR);
    rready_d     = (state_d == S_R) || pending_d;
    inst_valid_d = (state_d == S_OUT);
  end

  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = inst_err_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a transaction-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_ifu_fetch;

  localparam int unsigned MAXW = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic        pc_update;

  int n_cmp;
  int n_bad;

  ifu_fetch #(.MAX_WAIT(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_err   (inst_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc_update  (pc_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: address phase open, data phase open, instruction shown,
  // and a count of responses still owed by memory for abandoned requests.
  logic        m_addr_open;
  logic        m_data_open;
  logic        m_show;
  logic        m_killed;
  int          m_owed;
  int          m_rcycles;
  logic [31:0] m_addr;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic [1:0]  m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr_open <= 1'b0;
      m_data_open <= 1'b0;
      m_show      <= 1'b0;
      m_killed    <= 1'b0;
      m_owed      <= 0;
      m_rcycles   <= 0;
      m_addr      <= '0;
      m_inst      <= '0;
      m_ipc       <= '0;
      m_err       <= 2'd0;
    end else begin
      if (m_owed > 0 && rvalid) m_owed <= m_owed - 1;
      if (m_addr_open) begin
        if (flush) m_killed <= 1'b1;
        if (arready) begin
          m_addr_open <= 1'b0;
          m_killed    <= 1'b0;
          if (m_killed || flush) m_owed <= m_owed + 1;
          else begin
            m_data_open <= 1'b1;
            m_rcycles   <= 0;
          end
        end
      end else if (m_data_open) begin
        if (rvalid) begin
          m_data_open <= 1'b0;
          if (!flush) begin
            m_show <= 1'b1;
            m_inst <= rdata;
            m_err  <= (rresp == 2'b00) ? 2'd0 : 2'd2;
          end
        end else if (flush) begin
          m_data_open <= 1'b0;
          m_owed      <= m_owed + 1;
        end else begin
          m_rcycles <= m_rcycles + 1;
          if (m_rcycles + 1 == int'(MAXW)) begin
            m_data_open <= 1'b0;
            m_show      <= 1'b1;
            m_inst      <= '0;
            m_err       <= 2'd3;
            m_owed      <= m_owed + 1;
          end
        end
      end else if (m_show) begin
        if (flush || inst_ready) m_show <= 1'b0;
      end else if (fetch_en && !flush && m_owed == 0) begin
        m_addr <= pc;
        m_ipc  <= pc;
        if (pc % 4 == 0) m_addr_open <= 1'b1;
        else begin
          m_show <= 1'b1;
          m_inst <= '0;
          m_err  <= 2'd1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("arvalid", 32'(arvalid), 32'(m_addr_open));
      check("rready", 32'(rready), 32'(m_data_open || m_owed > 0));
      check("inst_valid", 32'(inst_valid), 32'(m_show));
      check("pc_update", 32'(pc_update), 32'(m_show && inst_ready && !flush && !rst));
      if (m_addr_open) check("araddr", araddr, m_addr);
      if (m_show) begin
        check("inst", inst, m_inst);
        check("inst_pc", inst_pc, m_ipc);
        check("inst_err", 32'(inst_err), 32'(m_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    pc         = '0;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    arready    = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    rvalid     = 1'b0;
    inst_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_inst", inst, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Minimum-latency fetch.
    pc = 32'h8000_0000; fetch_en = 1'b1; arready = 1'b1; inst_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("t1_arvalid", 32'(arvalid), 32'd1);
    check("t1_araddr", araddr, 32'h8000_0000);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0413;
    check("t1_rready", 32'(rready), 32'd1);
    tick();
    rvalid = 1'b0;
    check("t1_inst_valid", 32'(inst_valid), 32'd1);
    check("t1_inst", inst, 32'h0000_0413);
    check("t1_inst_pc", inst_pc, 32'h8000_0000);
    check("t1_inst_err", 32'(inst_err), 32'd0);
    check("t1_pc_update", 32'(pc_update), 32'd1);
    tick();
    check("t1_pc_update_drop", 32'(pc_update), 32'd0);
    check("t1_inst_valid_drop", 32'(inst_valid), 32'd0);
    inst_ready = 1'b0;

    // Address back-pressure, then decode back-pressure.
    pc = 32'h8000_0010; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_arvalid_hold", 32'(arvalid), 32'd1);
      check("t2_araddr_hold", araddr, 32'h8000_0010);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_inst_hold", inst, 32'h1234_5678);
      check("t2_pc_update_low", 32'(pc_update), 32'd0);
      tick();
    end
    inst_ready = 1'b1;
    #1;
    check("t2_pc_update", 32'(pc_update), 32'd1);
    tick();
    inst_ready = 1'b0;

    // Misaligned pc: no bus request.
    pc = 32'h8000_0002; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("t3_no_arvalid", 32'(arvalid), 32'd0);
    check("t3_inst_valid", 32'(inst_valid), 32'd1);
    check("t3_inst_err", 32'(inst_err), 32'd1);
    check("t3_inst_zero", inst, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Bus error response.
    pc = 32'h8000_0020; fetch_en = 1'b1; arready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    check("t4_inst_err", 32'(inst_err), 32'd2);
    check("t4_inst", inst, 32'hDEAD_BEEF);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Timeout after MAXW cycles in R; late response absorbed before the next fetch.
    pc = 32'h8000_0040; fetch_en = 1'b1; arready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    arready = 1'b0;
    for (int i = 0; i < int'(MAXW) - 1; i++) begin
      tick();
      check("t5_no_early_timeout", 32'(inst_valid), 32'd0);
    end
    tick();
    check("t5_inst_valid", 32'(inst_valid), 32'd1);
    check("t5_inst_err", 32'(inst_err), 32'd3);
    check("t5_inst_zero", inst, 32'd0);
    check("t5_rready_pending", 32'(rready), 32'd1);
    pc = 32'h8000_0080; fetch_en = 1'b1; inst_ready = 1'b1;
    tick();
    check("t5_blocked_a", 32'(arvalid), 32'd0);
    tick();
    check("t5_blocked_b", 32'(arvalid), 32'd0);
    check("t5_rready_late", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'h0000_0BAD;
    tick();
    rvalid = 1'b0;
    check("t5_pending_clear", 32'(rready), 32'd0);
    check("t5_still_idle", 32'(arvalid), 32'd0);
    tick();
    check("t5_issue", 32'(arvalid), 32'd1);
    check("t5_issue_addr", araddr, 32'h8000_0080);
    fetch_en = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0073;
    tick();
    rvalid = 1'b0;
    check("t5_next_inst", inst, 32'h0010_0073);
    tick();
    inst_ready = 1'b0;

    // Flush while the address waits for arready.
    pc = 32'h8000_0100; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; flush = 1'b1;
    check("t6_arvalid_a", 32'(arvalid), 32'd1);
    tick();
    flush = 1'b0;
    check("t6_arvalid_b", 32'(arvalid), 32'd1);
    tick();
    check("t6_arvalid_c", 32'(arvalid), 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("t6_arvalid_off", 32'(arvalid), 32'd0);
    check("t6_pending", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'h0000_0055;
    tick();
    rvalid = 1'b0;
    check("t6_discard_rready", 32'(rready), 32'd0);
    check("t6_no_inst", 32'(inst_valid), 32'd0);
    tick();

    // Flush in OUT with inst_ready in the same cycle.
    pc = 32'h8000_0200; fetch_en = 1'b1; arready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0077;
    tick();
    rvalid = 1'b0; flush = 1'b1; inst_ready = 1'b1;
    #1;
    check("t7_pc_update_blocked", 32'(pc_update), 32'd0);
    check("t7_inst_valid", 32'(inst_valid), 32'd1);
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    check("t7_inst_valid_drop", 32'(inst_valid), 32'd0);

    // Flush while waiting for read data.
    pc = 32'h8000_0300; fetch_en = 1'b1; arready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    arready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t8_pending", 32'(rready), 32'd1);
    check("t8_no_inst", 32'(inst_valid), 32'd0);
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    check("t8_pending_clear", 32'(rready), 32'd0);

    // Reset while in R.
    pc = 32'h8000_0400; fetch_en = 1'b1; arready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    arready = 1'b0;
    check("t9_in_r", 32'(rready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t9_rready", 32'(rready), 32'd0);
    check("t9_arvalid", 32'(arvalid), 32'd0);
    check("t9_inst_valid", 32'(inst_valid), 32'd0);
    check("t9_araddr", araddr, 32'd0);
    check("t9_inst_pc", inst_pc, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Normal fetch after reset.
    pc = 32'h8000_0500; fetch_en = 1'b1; arready = 1'b1; inst_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0013;
    tick();
    rvalid = 1'b0;
    check("t10_inst", inst, 32'hCAFE_0013);
    check("t10_inst_pc", inst_pc, 32'h8000_0500);
    tick();
    inst_ready = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
